// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: types and constants shared by the memory arbiter files.
//   arb_state_t  : arbiter FSM state (IDLE / WAIT / RESP)
//   OWN_IF/OWN_D : encoding of which requester owns the access in flight
//   MEM_LAT_MAX / STARVE_LIMIT : largest legal MEM_LAT / STARVE_MAX values
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int MEM_LAT_MAX  = 8;
  localparam int STARVE_LIMIT = 15;

  // Clamp a parameter into [lo, hi] and return it as a 4-bit counter value.
  function automatic logic [3:0] clamp4(input int v, input int lo, input int hi);
    int r;
    r = (v < lo) ? lo : ((v > hi) ? hi : v);
    return 4'(r);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and RAM command bus of the
// memory arbiter.
//   master modport : the arbiter (drives acks, read data, RAM command)
//   slave  modport : the environment (requesters and the RAM)
//
// Handshake: a requester raises *_req with a stable command and holds it
// until the matching *_ack pulse (one cycle); it may drop or renew the
// request in the ack cycle or later. mem_en is a one-cycle command strobe,
// and mem_rdata is sampled MEM_LAT cycles after it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter_perf.sv
// mem_arb_perf: free-running 32-bit event counters for the memory arbiter.
//   clk, rstn       : clock, synchronous active-low reset
//   grant_fire      : an access is granted this cycle
//   grant_if        : the grant (if any) goes to the fetch port
//   conflict        : arbiter idle with both requests high
//   perf_if_grants  : number of fetch grants (wraps)
//   perf_d_grants   : number of load/store grants (wraps)
//   perf_conflicts  : number of conflict cycles (wraps)
module mem_arb_perf (
  input  logic        clk,
  input  logic        rstn,
  input  logic        grant_fire,
  input  logic        grant_if,
  input  logic        conflict,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_conflicts
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_if_grants <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant_fire && grant_if)  perf_if_grants <= perf_if_grants + 32'd1;
      if (grant_fire && !grant_if) perf_d_grants  <= perf_d_grants + 32'd1;
      if (conflict)                perf_conflicts <= perf_conflicts + 32'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the IF fetch port and the
// MEM load/store port. One access at a time: IDLE arbitrates and registers
// the RAM command, WAIT covers the RAM read latency and captures read data,
// RESP pulses the owner's ack. Loads/stores win unless the fetch port has
// lost STARVE_MAX times in a row.
//   clk, rstn  : clock, synchronous active-low reset
//   bus        : mem_arbiter_if.master (requester ports and RAM command)
//   dbg_state  : current FSM state, for observation only
// Optional build macro MEM_ARB_PERF_EN adds perf_if_grants, perf_d_grants
// and perf_conflicts (32-bit wrapping counters, see mem_arb_perf).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rstn,
  mem_arbiter_if.master bus,
  output arb_state_t dbg_state
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_conflicts
`endif
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [3:0] LAT_C    = clamp4(MEM_LAT, 1, MEM_LAT_MAX);
  localparam logic [3:0] STARVE_C = clamp4(STARVE_MAX, 1, STARVE_LIMIT);

  arb_state_t        state;
  logic [3:0]        cnt;
  logic [3:0]        starve;
  logic              owner;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ack_q;
  logic              d_ack_q;

  logic              grant_fire;
  logic              grant_if;

  // Fetch wins when it is alone, or when it has been starved long enough.
  assign grant_fire = (state == IDLE) && (bus.if_req || bus.d_req);
  assign grant_if   = bus.if_req && (!bus.d_req || (starve == STARVE_C));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      starve      <= '0;
      owner       <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            state    <= WAIT;
            cnt      <= LAT_C;
            mem_en_q <= 1'b1;
            if (grant_if) begin
              owner       <= OWN_IF;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '1;
              starve      <= '0;
            end else begin
              owner       <= OWN_D;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
              mem_wstrb_q <= bus.d_we ? bus.d_wstrb : '1;
              // Only a lost conflict counts as starvation.
              if (bus.if_req && (starve != STARVE_C)) starve <= starve + 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            if (owner == OWN_IF) begin
              if_rdata_q <= bus.mem_rdata;
              if_ack_q   <= 1'b1;
            end else begin
              // Stores return nothing; keep the last load result visible.
              if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
              d_ack_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign dbg_state     = state;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk            (clk),
    .rstn           (rstn),
    .grant_fire     (grant_fire),
    .grant_if       (grant_if),
    .conflict       ((state == IDLE) && bus.if_req && bus.d_req),
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. dut runs MEM_LAT=1,
// STARVE_MAX=4 against a byte-writable RAM model; dut3 runs MEM_LAT=3
// against a read-only RAM model for the latency sweep.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc3 ();
  arb_state_t st1, st3;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] pif1, pd1, pc1, pif3, pd3, pc3;
`endif

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn), .bus(ifc1.master), .dbg_state(st1)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_grants(pif1), .perf_d_grants(pd1), .perf_conflicts(pc1)
`endif
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rstn(rstn), .bus(ifc3.master), .dbg_state(st3)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_grants(pif3), .perf_d_grants(pd3), .perf_conflicts(pc3)
`endif
  );

  // ---------------- RAM models ----------------
  localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction

  // Latency 1: data valid only in the cycle after mem_en, garbage otherwise.
  always @(posedge clk) begin
    logic [31:0] w;
    if (ifc1.mem_en) begin
      if (ifc1.mem_we) begin
        w = mem_read(ifc1.mem_addr);
        for (int b = 0; b < 4; b++)
          if (ifc1.mem_wstrb[b]) w[8*b +: 8] = ifc1.mem_wdata[8*b +: 8];
        mem[ifc1.mem_addr] = w;
        ifc1.mem_rdata <= GARBAGE;
      end else begin
        ifc1.mem_rdata <= mem_read(ifc1.mem_addr);
      end
    end else begin
      ifc1.mem_rdata <= GARBAGE;
    end
  end

  // Latency 3: read-only, three-stage pipe.
  logic [31:0] p0, p1;
  always @(posedge clk) begin
    p0 <= ifc3.mem_en ? init_word(ifc3.mem_addr) : GARBAGE;
    p1 <= p0;
    ifc3.mem_rdata <= p1;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    ifc1.if_req = 1'b0;
    ifc1.d_req  = 1'b0;
  endtask

  typedef struct packed {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;  // owner's rdata at ack (d_rdata unchanged on stores)
    logic [31:0] exp_mem;    // RAM word at addr after the access
  } vec_t;

  // One isolated access on dut (MEM_LAT=1); the call cycle is T.
  task automatic do_access(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_if) begin
      ifc1.if_req  = 1'b1;
      ifc1.if_addr = v.addr;
    end else begin
      ifc1.d_req   = 1'b1;
      ifc1.d_we    = v.we;
      ifc1.d_addr  = v.addr;
      ifc1.d_wdata = v.wdata;
      ifc1.d_wstrb = v.wstrb;
    end
    step();  // T+1
    chk1($sformatf("%s_mem_en", tag), ifc1.mem_en, 1'b1);
    chk1($sformatf("%s_mem_we", tag), ifc1.mem_we, v.we);
    chk($sformatf("%s_mem_addr", tag), ifc1.mem_addr, v.addr);
    chk($sformatf("%s_mem_wstrb", tag), 32'(ifc1.mem_wstrb), 32'(v.we ? v.wstrb : 4'hF));
    if (v.we) chk($sformatf("%s_mem_wdata", tag), ifc1.mem_wdata, v.wdata);
    step();  // T+2
    chk1($sformatf("%s_mem_en_once", tag), ifc1.mem_en, 1'b0);
    chk1($sformatf("%s_ack_early", tag), ifc1.if_ack | ifc1.d_ack, 1'b0);
    step();  // T+3
    chk1($sformatf("%s_if_ack", tag), ifc1.if_ack, v.is_if);
    chk1($sformatf("%s_d_ack", tag), ifc1.d_ack, !v.is_if);
    chk($sformatf("%s_rdata", tag), v.is_if ? ifc1.if_rdata : ifc1.d_rdata, v.exp_rdata);
    drop_reqs();
    step();  // T+4
    chk1($sformatf("%s_ack_one_cycle", tag), ifc1.if_ack | ifc1.d_ack, 1'b0);
    chk1($sformatf("%s_idle", tag), st1 == IDLE, 1'b1);
    chk($sformatf("%s_ram", tag), mem_read(v.addr), v.exp_mem);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs [9];
    vec_t r;
    int   g, a, cyc;
    logic seen;
    logic exp_if;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hC0DE_0100, 32'hC0DE_0100};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 32'h0, 32'hC0DE_BEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_2004, 32'h0, 4'h0, 32'hC0DE_BEEF, 32'hC0DE_BEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1100, 32'hC0DE_BEEF, 32'h1234_0010};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_0010, 32'h1234_0010};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'h0, 32'hC0DE_BEEF, 32'hC0DE_BEEF};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0, 4'h0, 32'hC0DE_03FC, 32'hC0DE_03FC};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 32'h1234_0010, 32'hCAFE_F00D};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hCAFE_F00D, 32'hCAFE_F00D};

    ifc1.if_req = 1'b1; ifc1.if_addr = 32'h40;
    ifc1.d_req  = 1'b1; ifc1.d_we = 1'b1; ifc1.d_addr = 32'h80;
    ifc1.d_wdata = 32'h5555_AAAA; ifc1.d_wstrb = 4'hF;
    ifc3.if_req = 1'b0; ifc3.if_addr = '0;
    ifc3.d_req  = 1'b0; ifc3.d_we = 1'b0; ifc3.d_addr = '0;
    ifc3.d_wdata = '0; ifc3.d_wstrb = '0;

    // Reset with both requests held.
    rstn = 1'b0;
    step();
    step();
    chk1("rst_mem_en", ifc1.mem_en, 1'b0);
    chk1("rst_mem_we", ifc1.mem_we, 1'b0);
    chk("rst_mem_addr", ifc1.mem_addr, 32'h0);
    chk("rst_mem_wdata", ifc1.mem_wdata, 32'h0);
    chk("rst_mem_wstrb", 32'(ifc1.mem_wstrb), 32'h0);
    chk1("rst_acks", ifc1.if_ack | ifc1.d_ack, 1'b0);
    chk("rst_if_rdata", ifc1.if_rdata, 32'h0);
    chk("rst_d_rdata", ifc1.d_rdata, 32'h0);
    chk1("rst_state", st1 == IDLE, 1'b1);
`ifdef MEM_ARB_PERF_EN
    chk("rst_perf_if", pif1, 32'h0);
    chk("rst_perf_d", pd1, 32'h0);
    chk("rst_perf_conf", pc1, 32'h0);
`endif
    rstn = 1'b1;
    drop_reqs();

    // Single-requester vectors (first one is the post-reset fetch of 0x100).
    for (int i = 0; i < 9; i++) do_access(vecs[i], i);

    // Reset in the second WAIT cycle of a load.
    ifc1.d_req = 1'b1; ifc1.d_we = 1'b0; ifc1.d_addr = 32'h20;
    step();
    chk1("rwait_mem_en", ifc1.mem_en, 1'b1);
    step();
    rstn = 1'b0;
    drop_reqs();
    step();
    chk1("rwait_state", st1 == IDLE, 1'b1);
    chk1("rwait_no_ack", ifc1.if_ack | ifc1.d_ack, 1'b0);
    chk("rwait_d_rdata", ifc1.d_rdata, 32'h0);
    chk1("rwait_mem_en_clr", ifc1.mem_en, 1'b0);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | ifc1.if_ack | ifc1.d_ack;
    end
    chk1("rwait_never_ack", seen, 1'b0);
    r = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hC0DE_0100, 32'hC0DE_0100};
    do_access(r, 99);

    // Conflict: both held, expect D,D,D,D,IF repeating.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    ifc1.if_req = 1'b1; ifc1.if_addr = 32'h40;
    ifc1.d_req  = 1'b1; ifc1.d_we = 1'b0; ifc1.d_addr = 32'h80;
    g = 0; a = 0; cyc = 0;
    while (a < 10 && cyc < 200) begin
      step();
      cyc++;
      if (ifc1.mem_en) begin
        chk($sformatf("conf_grant%0d_addr", g), ifc1.mem_addr, (g % 5 == 4) ? 32'h40 : 32'h80);
        g++;
      end
      if (ifc1.if_ack || ifc1.d_ack) begin
        exp_if = (a % 5 == 4);
        chk1($sformatf("conf_ack%0d_if", a), ifc1.if_ack, exp_if);
        chk1($sformatf("conf_ack%0d_d", a), ifc1.d_ack, !exp_if);
        chk($sformatf("conf_ack%0d_rdata", a), exp_if ? ifc1.if_rdata : ifc1.d_rdata,
            exp_if ? 32'hC0DE_0040 : 32'hC0DE_0080);
        a++;
        if (a == 10) drop_reqs();
      end
    end
    chk("conf_ack_count", 32'(a), 32'd10);
    step();
    step();
    chk("conf_grant_count", 32'(g), 32'd10);
`ifdef MEM_ARB_PERF_EN
    chk("perf_d_grants", pd1, 32'd8);
    chk("perf_if_grants", pif1, 32'd2);
    chk("perf_conflicts", pc1, 32'd10);
`endif

    // Latency sweep on dut3 (MEM_LAT=3); request held past its ack.
    ifc3.d_req = 1'b1; ifc3.d_we = 1'b0; ifc3.d_addr = 32'h300;
    step();
    chk1("lat3_mem_en_t1", ifc3.mem_en, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk1($sformatf("lat3_no_ack_t%0d", k), ifc3.d_ack, 1'b0);
    end
    step();
    chk1("lat3_ack_t5", ifc3.d_ack, 1'b1);
    chk1("lat3_if_ack_t5", ifc3.if_ack, 1'b0);
    chk("lat3_rdata", ifc3.d_rdata, 32'hC0DE_0300);
    step();
    chk1("lat3_mem_en_t6", ifc3.mem_en, 1'b0);
    chk1("lat3_ack_t6", ifc3.d_ack, 1'b0);
    step();
    chk1("lat3_mem_en_t7", ifc3.mem_en, 1'b1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      step();
      cyc++;
      seen = ifc3.d_ack;
    end
    ifc3.d_req = 1'b0;
    chk1("lat3_second_ack", seen, 1'b1);
    chk("lat3_second_ack_cycle", 32'(cyc), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port instruction/data RAM between the IF-stage fetch port and the MEM-stage load/store port of the pipelined core. A three-state FSM grants one requester at a time. It issues one registered RAM command, waits a parameterised read latency, then returns data with a one-cycle ack pulse. Data accesses win by default; a starvation counter guarantees fetch progress. The pipeline stalls each stage while its request is high and its ack is low.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width; strobe width is DATA_W/8
- `MEM_LAT`, 1, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range is 1–8
- `STARVE_MAX`, 4, consecutive IF losses before IF is forced to win once; legal range is 1–15
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ack` is high
- `if_ack`  out  1  one-cycle completion pulse
- `d_req`  in  1  load/store request; held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  byte enables for stores
- `d_rdata`  out  DATA_W  load data; valid while `d_ack` is high
- `d_ack`  out  1  one-cycle completion pulse; also pulses for stores
- `mem_en`  out  1  RAM command strobe, one cycle per access
- `mem_we`  out  1  RAM write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  RAM address, qualified by `mem_en`
- `mem_wdata`  out  DATA_W  RAM write data, qualified by `mem_en`
- `mem_wstrb`  out  DATA_W/8  RAM byte enables; all ones on reads
- `mem_rdata`  in  DATA_W  RAM read data, valid MEM_LAT cycles after `mem_en`

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE:**
  - No request → stay in IDLE.
  - One or both requests high → arbitrate, latch the winner's command into the output registers, set `owner`, load `cnt`=MEM_LAT, go to WAIT.
- **Arbitration:**
  - Both requests high and `starve`<STARVE_MAX → D wins, and `starve` increments (saturating).
  - Both requests high and `starve`==STARVE_MAX → IF wins.
  - Any IF win clears `starve`.
  - D-only grants leave `starve` unchanged.
- **WAIT:**
  - `mem_en` is high only in the first WAIT cycle.
  - `cnt` decrements every cycle.
  - At `cnt`==0, `mem_rdata` is captured into the owner's rdata register and the FSM goes to RESP. WAIT lasts MEM_LAT+1 cycles.
- **RESP:**
  - The owner's ack is high for exactly one cycle; requests are ignored in this cycle.
  - The FSM then goes to IDLE.
- **Stores** follow the same path. The captured `mem_rdata` is don't-care, and the `d_rdata` register keeps its previous value.
- **Ack exclusivity:** `if_ack` and `d_ack` are never high together.
- **Requester contract:**
  - A requester does not change addr/data/we while its req is high.
  - A requester may drop req only in its ack cycle or later.
  - The arbiter does not check this contract.
- **Reset mid-access:** everything returns to reset values at the next edge and no ack is produced. A store already presented on `mem_en` is not retracted.

## Timing
- **Reset values:** state=IDLE; `cnt`=0; `starve`=0; all outputs 0, including `if_rdata`, `d_rdata`, `mem_addr`, `mem_wdata` and `mem_wstrb`.
- **Request at cycle T** (sampled in IDLE):
  - `mem_en` at T+1.
  - Data captured at the edge ending T+1+MEM_LAT.
  - Ack at T+2+MEM_LAT.
- **Latency** is MEM_LAT+2 cycles. Back-to-back throughput is one access per MEM_LAT+3 cycles. The next grant is at the earliest at T+3+MEM_LAT.
- **Registered outputs:** all outputs come from flops with no combinational path from inputs. `mem_*` hold their last values outside the `mem_en` cycle.
- **Counter widths:** `cnt` is 4 bits, `starve` is 4 bits, saturating at STARVE_MAX.

## Configuration
- `MEM_ARB_PERF_EN`: adds three 32-bit outputs:
  - `perf_if_grants`: counts IF grants.
  - `perf_d_grants`: counts D grants.
  - `perf_conflicts`: counts cycles in IDLE with both requests high.
- All three counters wrap modulo 2^32 and reset to 0.
- Without the macro, the ports and counters do not exist and the block behaves identically otherwise.

## Structure
- **Shared package `mem_arb_pkg`** holds:
  - the state enum `arb_state_t` (IDLE/WAIT/RESP);
  - the owner encoding `OWN_IF`=0 and `OWN_D`=1;
  - the parameter limits MEM_LAT_MAX=8 and STARVE_LIMIT=15.
- **Sub-module `mem_arb_perf`** holds the three counters. It is instantiated only under `MEM_ARB_PERF_EN`; the FSM stays in `mem_arbiter`.

## Test plan
- **Reset:** with both requests held, drive `rstn`=0 for 2 cycles → all outputs 0. Release; `if_req`=1, `if_addr`=0x100, MEM_LAT=1 → `mem_en` at T+1, `if_ack` at T+3 with the RAM word at 0x100.
- **Store:** `d_req`=1, `d_we`=1, `d_addr`=0x2004, `d_wdata`=0xDEADBEEF, `d_wstrb`=0b0011 → a single `mem_en` with `mem_we`=1, `mem_wstrb`=0b0011, `mem_addr`=0x2004; `d_ack` at T+3; `d_rdata` unchanged.
- **Conflict:** both requests held constantly, STARVE_MAX=4 → grant order D,D,D,D,IF repeating; `if_ack` every 5th access.
- **Latency sweep:** MEM_LAT=3 → ack at exactly T+5; next `mem_en` no earlier than T+7.
- **Reset in WAIT:** `rstn` low in the second WAIT cycle → no ack ever for that access; state IDLE. A request after release is served normally.
- **Perf counters** (`MEM_ARB_PERF_EN` defined): replay the conflict test for 10 accesses → `perf_d_grants`=8, `perf_if_grants`=2, `perf_conflicts`=10.
